// File: rtl/seq_window_sched_pkg.sv
// Shared constants and state encoding for the Q/R window scheduler.
package seq_sched_pkg;

   localparam int BP_W = 3;
   localparam int WIN  = 4;
   localparam logic [BP_W-1:0] PAD = 3'b111;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FILL,
      READY,
      SHIFT,
      DONE
   } sched_state_t;

endpackage

// File: rtl/seq_window_sched_if.sv
// Bundle of stream, shift-register and control signals around the scheduler.
// slave is the scheduler side, master is the surrounding accelerator.
interface seq_window_sched_if #(parameter int LEN_W = 16);
   import seq_sched_pkg::*;

   logic              start;
   logic [LEN_W-1:0]  q_len;
   logic [LEN_W-1:0]  r_len;
   logic              q_base_valid;
   logic [BP_W-1:0]   q_base;
   logic              q_base_ready;
   logic              r_base_valid;
   logic [BP_W-1:0]   r_base;
   logic              r_base_ready;
   logic              q_en;
   logic              q_dir;
   logic [BP_W-1:0]   q_in;
   logic              r_en;
   logic              r_dir;
   logic [BP_W-1:0]   r_in;
   logic              sr_clear;
   logic              step_q;
   logic              step_r;
   logic              window_valid;
   logic              busy;
   logic              done;

   modport slave (
      input  start, q_len, r_len,
      input  q_base_valid, q_base, r_base_valid, r_base,
      input  step_q, step_r,
      output q_base_ready, r_base_ready,
      output q_en, q_dir, q_in, r_en, r_dir, r_in, sr_clear,
      output window_valid, busy, done
   );

   modport master (
      output start, q_len, r_len,
      output q_base_valid, q_base, r_base_valid, r_base,
      output step_q, step_r,
      input  q_base_ready, r_base_ready,
      input  q_en, q_dir, q_in, r_en, r_dir, r_in, sr_clear,
      input  window_valid, busy, done
   );

endinterface

// File: rtl/seq_window_sched_side_feeder.sv
// One side (Q or R) of the scheduler: tracks how many bases were pulled from
// the stream and how far the window has advanced, and decides per shift
// whether to take a stream base or insert PAD.
//
// Handshake: a base moves when base_valid & base_ready are both high at a
// rising edge. base_ready only depends on state/counters (never on
// base_valid); once valid is raised the source holds base stable until the
// transfer. en is raised in that same cycle so the shift register captures
// the base on the transfer edge. Reset forces ready and en low, so an
// offered base is left with the source.
module side_feeder
   import seq_sched_pkg::*;
#(parameter int LEN_W = 16) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [LEN_W-1:0] len_in,
   input  logic             fill,
   input  logic             shift_req,
   input  logic             base_valid,
   input  logic [BP_W-1:0]  base,
   output logic             base_ready,
   output logic             en,
   output logic [BP_W-1:0]  in,
   output logic             shift_done,
   output logic             fill_done,
   output logic             at_end
);

   localparam int FC_W = $clog2(WIN + 1);

   logic [LEN_W-1:0] len;
   logic [LEN_W:0]   fetched;
   logic [LEN_W:0]   pos;
   logic [FC_W-1:0]  fill_cnt;
   logic             have_data;
   logic             active;

   // Fetch/pad decision for the current cycle; pad shifts never wait on the stream.
   always_comb begin
      have_data  = fetched < {1'b0, len};
      active     = !reset && ((fill && fill_cnt != FC_W'(WIN)) || shift_req);
      base_ready = active && have_data;
      en         = active && (!have_data || base_valid);
      in         = '0;
      if (en) in = have_data ? base : PAD;
      shift_done = en;
      // Looks one edge ahead so FILL can leave on the cycle of the last shift.
      fill_done  = (fill_cnt == FC_W'(WIN)) ||
                   (fill && en && fill_cnt == FC_W'(WIN - 1));
      at_end     = pos == {1'b0, len};
   end

   // Length latch and per-run counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         len      <= '0;
         fetched  <= '0;
         pos      <= '0;
         fill_cnt <= '0;
      end else if (load) begin
         len      <= len_in;
         fetched  <= '0;
         pos      <= '0;
         fill_cnt <= '0;
      end else begin
         if (en && have_data) fetched  <= fetched + (LEN_W + 1)'(1);
         if (en && fill)      fill_cnt <= fill_cnt + FC_W'(1);
         if (en && shift_req) pos      <= pos + (LEN_W + 1)'(1);
      end
   end

endmodule

// File: rtl/seq_window_sched.sv
// Sequencer for the Q and R shift-register windows: fills both windows,
// then advances either side on step requests until both are exhausted.
module seq_window_sched
   import seq_sched_pkg::*;
#(parameter int LEN_W = 16) (
   input  logic               clk,
   input  logic               reset,
   seq_window_sched_if.slave  bus,
   output sched_state_t       dbg_state
);

   sched_state_t state;
   sched_state_t state_n;
   logic pend_q, pend_r;
   logic pend_q_n, pend_r_n;
   logic load;
   logic q_fill_done, r_fill_done;
   logic q_at_end, r_at_end;
   logic q_shift_done, r_shift_done;

   assign load      = (state == IDLE) && bus.start;
   assign bus.q_dir = 1'b0;
   assign bus.r_dir = 1'b1;
   assign dbg_state = state;

   side_feeder #(.LEN_W(LEN_W)) u_q (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .len_in     (bus.q_len),
      .fill       (state == FILL),
      .shift_req  (state == SHIFT && pend_q),
      .base_valid (bus.q_base_valid),
      .base       (bus.q_base),
      .base_ready (bus.q_base_ready),
      .en         (bus.q_en),
      .in         (bus.q_in),
      .shift_done (q_shift_done),
      .fill_done  (q_fill_done),
      .at_end     (q_at_end)
   );

   side_feeder #(.LEN_W(LEN_W)) u_r (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .len_in     (bus.r_len),
      .fill       (state == FILL),
      .shift_req  (state == SHIFT && pend_r),
      .base_valid (bus.r_base_valid),
      .base       (bus.r_base),
      .base_ready (bus.r_base_ready),
      .en         (bus.r_en),
      .in         (bus.r_in),
      .shift_done (r_shift_done),
      .fill_done  (r_fill_done),
      .at_end     (r_at_end)
   );

   // Next state and step latching; steps on an exhausted side are dropped.
   always_comb begin
      state_n  = state;
      pend_q_n = pend_q;
      pend_r_n = pend_r;
      case (state)
         IDLE:  if (bus.start) state_n = CLEAR;
         CLEAR: state_n = FILL;
         FILL:  if (q_fill_done && r_fill_done) state_n = READY;
         READY: begin
            if (q_at_end && r_at_end) begin
               state_n = DONE;
            end else if ((bus.step_q && !q_at_end) || (bus.step_r && !r_at_end)) begin
               state_n  = SHIFT;
               pend_q_n = bus.step_q && !q_at_end;
               pend_r_n = bus.step_r && !r_at_end;
            end
         end
         SHIFT: begin
            pend_q_n = pend_q && !q_shift_done;
            pend_r_n = pend_r && !r_shift_done;
            if (!pend_q_n && !pend_r_n) state_n = READY;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // State register with status outputs decoded from the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= IDLE;
         pend_q           <= 1'b0;
         pend_r           <= 1'b0;
         bus.sr_clear     <= 1'b0;
         bus.window_valid <= 1'b0;
         bus.busy         <= 1'b0;
         bus.done         <= 1'b0;
      end else begin
         state            <= state_n;
         pend_q           <= pend_q_n;
         pend_r           <= pend_r_n;
         bus.sr_clear     <= state_n == CLEAR;
         bus.window_valid <= state_n == READY;
         bus.busy         <= state_n != IDLE;
         bus.done         <= state_n == DONE;
      end
   end

endmodule
